tree_accum_sum: RTL



---
 rtl/tree_sum_pkg.sv | 18 +
 rtl/tree_add_stage.sv | 58 +++++
 rtl/tree_accum_sum.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tree_sum_pkg.sv
// Shared types and width helpers for the pipelined K-lane reduction tree.
package tree_sum_pkg;

  typedef enum logic {
    TREE_SUM = 1'b0,
    TREE_ACC = 1'b1
  } tree_mode_e;

  // Width of each partial sum held in register stage s.
  function automatic int stage_w(input int width, input int s);
    return width + s + 1;
  endfunction

  function automatic int out_w(input int width, input int k, input int acc_beats);
    return width + $clog2(k) + $clog2(acc_beats);
  endfunction

endpackage

// File: rtl/tree_add_stage.sv
// One tree level: sign-extended pairwise adds of N_IN lanes into N_IN/2
// registered sums, with valid and mode/last sideband carried alongside.
module tree_add_stage
  import tree_sum_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int IN_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic                          i_valid,
  input  tree_mode_e                    i_mode,
  input  logic                          i_last,
  input  logic [N_IN*IN_W-1:0]          i_data,
  output logic                          o_valid,
  output tree_mode_e                    o_mode,
  output logic                          o_last,
  output logic [(N_IN/2)*(IN_W+1)-1:0]  o_data
);

  localparam int N_OUT = N_IN / 2;
  localparam int SUM_W = IN_W + 1;

  logic [N_OUT*SUM_W-1:0] w_sum;
  logic [N_OUT*SUM_W-1:0] r_data;
  logic                   r_valid;
  tree_mode_e             r_mode;
  logic                   r_last;

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    logic signed [IN_W-1:0] w_a;
    logic signed [IN_W-1:0] w_b;
    assign w_a = i_data[(2*j)*IN_W +: IN_W];
    assign w_b = i_data[(2*j+1)*IN_W +: IN_W];
    assign w_sum[j*SUM_W +: SUM_W] = SUM_W'(w_a) + SUM_W'(w_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_mode  <= TREE_SUM;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_mode  <= i_mode;
      r_last  <= i_last;
      r_data  <= w_sum;
    end
  end

  assign o_valid = r_valid;
  assign o_mode  = r_mode;
  assign o_last  = r_last;
  assign o_data  = r_data;

endmodule

// File: rtl/tree_accum_sum.sv
// Pipelined signed K-lane reduction tree with valid/ready handshake and an
// optional multi-beat accumulate mode delimited by in_last.
module tree_accum_sum
  import tree_sum_pkg::*;
#(
  parameter int K         = 16,
  parameter int WIDTH     = 13,
  parameter int ACC_BEATS = 256,
  parameter int OUT_W     = out_w(WIDTH, K, ACC_BEATS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [K*WIDTH-1:0]      in_data,
  input  logic                    in_mode,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_sum
);

  localparam int L      = $clog2(K);
  localparam int TREE_W = WIDTH + L;

  logic w_en;
  logic r_out_valid;
  logic signed [OUT_W-1:0] r_out_sum;
  logic signed [OUT_W-1:0] r_acc;
  logic r_open;

  // Whole pipeline freezes together so held results and bubbles stay aligned.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int IN_W = stage_w(WIDTH, s) - 1;
    localparam int N_IN = K >> s;

    logic [N_IN*IN_W-1:0]          w_in_data;
    logic                          w_in_valid;
    tree_mode_e                    w_in_mode;
    logic                          w_in_last;
    logic [(N_IN/2)*(IN_W+1)-1:0]  w_data;
    logic                          w_valid;
    tree_mode_e                    w_mode;
    logic                          w_last;

    if (s == 0) begin : g_first
      assign w_in_data  = in_data;
      assign w_in_valid = in_valid;
      assign w_in_mode  = tree_mode_e'(in_mode);
      assign w_in_last  = in_last;
    end else begin : g_next
      assign w_in_data  = g_stage[s-1].w_data;
      assign w_in_valid = g_stage[s-1].w_valid;
      assign w_in_mode  = g_stage[s-1].w_mode;
      assign w_in_last  = g_stage[s-1].w_last;
    end

    tree_add_stage #(
      .N_IN (N_IN),
      .IN_W (IN_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_valid (w_in_valid),
      .i_mode  (w_in_mode),
      .i_last  (w_in_last),
      .i_data  (w_in_data),
      .o_valid (w_valid),
      .o_mode  (w_mode),
      .o_last  (w_last),
      .o_data  (w_data)
    );
  end

  logic signed [TREE_W-1:0] w_tree_sum;
  logic signed [OUT_W-1:0]  w_tree_ext;
  logic signed [OUT_W-1:0]  w_acc_base;
  logic signed [OUT_W-1:0]  w_acc_sum;
  logic                     w_tree_valid;
  tree_mode_e               w_tree_mode;
  logic                     w_tree_last;

  assign w_tree_sum   = g_stage[L-1].w_data;
  assign w_tree_valid = g_stage[L-1].w_valid;
  assign w_tree_mode  = g_stage[L-1].w_mode;
  assign w_tree_last  = g_stage[L-1].w_last;
  assign w_tree_ext   = OUT_W'(w_tree_sum);
  assign w_acc_base   = r_open ? r_acc : '0;
  assign w_acc_sum    = w_acc_base + w_tree_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_acc       <= '0;
      r_open      <= 1'b0;
    end else if (w_en) begin
      if (!w_tree_valid) begin
        r_out_valid <= 1'b0;
      end else if (w_tree_mode == TREE_SUM) begin
        r_out_sum   <= w_tree_ext;
        r_out_valid <= 1'b1;
      end else if (w_tree_last) begin
        r_out_sum   <= w_acc_sum;
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_open      <= 1'b0;
      end else begin
        r_acc       <= w_acc_sum;
        r_open      <= 1'b1;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;

endmodule
